// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU control into an Operation code and buffers operands in a 2-entry skid.
// Optional ALU_ISSUE_PERF_EN adds perf_issued/perf_stall counters.
module alu_issue_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               alu_op,
    input  logic [2:0]               funct3,
    input  logic                     funct7b5,
    input  logic                     alu_src,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_stall,
`endif
    output logic                     out_illegal
);

    localparam logic [OPCODE_LENGTH-1:0] OpAnd = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OpOr  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OpAdd = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OpSub = OPCODE_LENGTH'(4'b0011);
    localparam logic [OPCODE_LENGTH-1:0] OpSll = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OpSrl = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OpSra = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OpEq  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OpXor = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OpLt  = OPCODE_LENGTH'(4'b1100);

    typedef struct packed {
        logic                     illegal;
        logic [OPCODE_LENGTH-1:0] op;
        logic [DATA_WIDTH-1:0]    a;
        logic [DATA_WIDTH-1:0]    b;
    } entry_t;

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_illegal;
    logic                     dec_shift;
    logic [DATA_WIDTH-1:0]    src_b_raw;
    entry_t                   new_entry;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q;
    logic   accept, consume;

    always_comb begin
        dec_op      = OpAdd;
        dec_illegal = 1'b0;
        unique case (alu_op)
            2'b00: dec_op = OpAdd;
            2'b01: begin
                unique case (funct3)
                    3'b000, 3'b001: dec_op = OpEq;
                    // Unsupported branch compares travel as illegal with a neutral code.
                    3'b010, 3'b011: begin
                        dec_op      = OpAnd;
                        dec_illegal = 1'b1;
                    end
                    default: dec_op = OpLt;
                endcase
            end
            2'b10, 2'b11: begin
                unique case (funct3)
                    3'b000: dec_op = (alu_op == 2'b10 && funct7b5) ? OpSub : OpAdd;
                    3'b001: dec_op = OpSll;
                    3'b010: dec_op = OpLt;
                    3'b011: begin
                        dec_op      = OpAnd;
                        dec_illegal = 1'b1;
                    end
                    3'b100: dec_op = OpXor;
                    3'b101: dec_op = funct7b5 ? OpSra : OpSrl;
                    3'b110: dec_op = OpOr;
                    3'b111: dec_op = OpAnd;
                endcase
            end
        endcase
    end

    assign dec_shift = (dec_op == OpSll) || (dec_op == OpSrl) || (dec_op == OpSra);
    assign src_b_raw = alu_src ? imm : rs2_data;

    always_comb begin
        new_entry.illegal = dec_illegal;
        new_entry.op      = dec_op;
        new_entry.a       = rs1_data;
        new_entry.b       = src_b_raw;
        // The ALU takes its shift amount from SrcB[24:20].
        if (dec_shift) begin
            new_entry.b        = '0;
            new_entry.b[24:20] = src_b_raw[4:0];
        end
    end

    assign accept  = in_valid && in_ready_q;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || consume) begin
            // Skid entry is older than anything arriving now, so it moves up first.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = new_entry;
                end
            end else if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (consume) begin
                perf_issued_q <= perf_issued_q + 32'd1;
            end
            if (main_valid_q && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign SrcA        = main_q.a;
    assign SrcB        = main_q.b;
    assign Operation   = main_q.op;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: decode sweep, backpressure, flush and reset mid-stream.
module tb_alu_issue_stage;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5, alu_src;
    logic [31:0] rs1_data, rs2_data, imm;
    logic        out_valid, out_ready, out_illegal;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    exp_t exp_q[$];

    alu_issue_stage #(
        .DATA_WIDTH(32),
        .OPCODE_LENGTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_op(alu_op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .alu_src(alu_src),
        .rs1_data(rs1_data),
        .rs2_data(rs2_data),
        .imm(imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .SrcA(SrcA),
        .SrcB(SrcB),
        .Operation(Operation),
`ifdef ALU_ISSUE_PERF_EN
        .perf_issued(perf_issued),
        .perf_stall(perf_stall),
`endif
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode written as a flat table over (alu_op, funct3, funct7b5).
    function automatic exp_t model(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                   input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [31:0] im);
        exp_t e;
        logic [31:0] b;
        e.ill = 1'b0;
        e.a   = rs1;
        if (aop == 2'd0) begin
            e.op = 4'b0010;
        end else if (aop == 2'd1) begin
            if (f3[2]) e.op = 4'b1100;
            else if (f3[1]) begin
                e.op  = 4'b0000;
                e.ill = 1'b1;
            end else e.op = 4'b1000;
        end else begin
            case (f3)
                3'd0: e.op = (aop == 2'd2 && f7) ? 4'b0011 : 4'b0010;
                3'd1: e.op = 4'b0100;
                3'd2: e.op = 4'b1100;
                3'd3: begin
                    e.op  = 4'b0000;
                    e.ill = 1'b1;
                end
                3'd4: e.op = 4'b1001;
                3'd5: e.op = f7 ? 4'b0111 : 4'b0101;
                3'd6: e.op = 4'b0001;
                default: e.op = 4'b0000;
            endcase
        end
        b = src ? im : rs2;
        if (e.op == 4'b0100 || e.op == 4'b0101 || e.op == 4'b0111) b = {7'b0, b[4:0], 20'b0};
        e.b = b;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                        input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] im);
        logic rdy;
        bit   ok = 1'b0;
        alu_op = aop; funct3 = f3; funct7b5 = f7; alu_src = src;
        rs1_data = rs1; rs2_data = rs2; imm = im;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) exp_q.push_back(model(aop, f3, f7, src, rs1, rs2, im));
        else check("accept_timeout", 64'd0, 64'd1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pop on handshake, stability while stalled.
    initial begin
        exp_t e;
        bit          hold = 1'b0;
        logic [3:0]  h_op;
        logic [31:0] h_a, h_b;
        logic        h_ill;
        forever begin
            @(negedge clk);
            if (!reset && !flush) begin
                if (hold) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_op", 64'(Operation), 64'(h_op));
                    check("hold_srca", 64'(SrcA), 64'(h_a));
                    check("hold_srcb", 64'(SrcB), 64'(h_b));
                    check("hold_ill", 64'(out_illegal), 64'(h_ill));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        pops++;
                        check("sb_op", 64'(Operation), 64'(e.op));
                        check("sb_srca", 64'(SrcA), 64'(e.a));
                        check("sb_srcb", 64'(SrcB), 64'(e.b));
                        check("sb_ill", 64'(out_illegal), 64'(e.ill));
                    end
                end
                hold  = out_valid && !out_ready;
                h_op  = Operation;
                h_a   = SrcA;
                h_b   = SrcB;
                h_ill = out_illegal;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit done;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; funct3 = '0; funct7b5 = 1'b0; alu_src = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_srca", 64'(SrcA), 64'd0);
        check("rst_srcb", 64'(SrcB), 64'd0);
        check("rst_op", 64'(Operation), 64'd0);
        check("rst_ill", 64'(out_illegal), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // R-type SUB, one-cycle latency
        send(2'b10, 3'b000, 1'b1, 1'b0, 32'd10, 32'd3, 32'd0);
        @(negedge clk);
        check("sub_valid", 64'(out_valid), 64'd1);
        check("sub_op", 64'(Operation), 64'h3);
        check("sub_srca", 64'(SrcA), 64'd10);
        check("sub_srcb", 64'(SrcB), 64'd3);
        @(posedge clk); #1;

        // SRAI shift amount placement
        send(2'b11, 3'b101, 1'b1, 1'b1, 32'h1234, 32'hffff_ffff, 32'h405);
        @(negedge clk);
        check("srai_op", 64'(Operation), 64'h7);
        check("srai_srcb", 64'(SrcB), 64'h0050_0000);
        @(posedge clk); #1;

        // Branch BLT and unsupported branch
        send(2'b01, 3'b100, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0);
        @(negedge clk);
        check("blt_op", 64'(Operation), 64'hc);
        @(posedge clk); #1;
        send(2'b01, 3'b010, 1'b0, 1'b0, 32'd5, 32'd6, 32'd0);
        @(negedge clk);
        check("bill_op", 64'(Operation), 64'h0);
        check("bill_ill", 64'(out_illegal), 64'd1);
        @(posedge clk); #1;
        drain();

        // Full decode sweep with random backpressure
        done = 1'b0;
        fork
            begin
                for (int a = 0; a < 4; a++)
                    for (int f = 0; f < 8; f++)
                        for (int s = 0; s < 2; s++)
                            send(2'(a), 3'(f), 1'(s), 1'($urandom_range(1)), $urandom,
                                 $urandom, $urandom);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Backpressure: A in main, B in skid, C stalls
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(2'b10, 3'b111, 1'b0, 1'b0, 32'hA, 32'h1, 32'h0);
        send(2'b10, 3'b110, 1'b0, 1'b0, 32'hB, 32'h2, 32'h0);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_main_a", 64'(SrcA), 64'hA);
        @(posedge clk); #1;
        fork
            send(2'b10, 3'b100, 1'b0, 1'b0, 32'hC, 32'h3, 32'h0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush with both entries full and a new entry presented
        out_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 1'b1, 32'h11, 32'h0, 32'h4);
        send(2'b00, 3'b000, 1'b0, 1'b1, 32'h22, 32'h0, 32'h8);
        in_valid = 1'b1; rs1_data = 32'hdead; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("flush_no_ghost", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Reset mid-stream, then five entries
        out_ready = 1'b0;
        send(2'b10, 3'b001, 1'b0, 1'b0, 32'h33, 32'h7, 32'h0);
        send(2'b10, 3'b010, 1'b0, 1'b0, 32'h44, 32'h8, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_in_ready", 64'(in_ready), 64'd1);
        check("mrst_srca", 64'(SrcA), 64'd0);
        check("mrst_srcb", 64'(SrcB), 64'd0);
        check("mrst_op", 64'(Operation), 64'd0);
        check("mrst_ill", 64'(out_illegal), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 5; i++)
            send(2'b11, 3'(i), 1'b0, 1'b1, 32'(i * 3), 32'h0, 32'(i + 1));
        drain();
        check("mrst_pops", 64'(pops), 64'd5);
`ifdef ALU_ISSUE_PERF_EN
        check("perf_issued", 64'(perf_issued), 64'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
